// File: rtl/uart_tx_buffer_pkg.sv
// Shared SoC definitions for the UART transmit buffer.
// Holds the drain FSM state encodings and the default FIFO depth. The SoC
// MMIO decoder imports the same package.
package uart_tx_buffer_pkg;

  localparam int unsigned DEFAULT_DEPTH = 16;
  localparam int unsigned BYTE_W        = 8;

  // Cycles WAIT_BUSY tolerates tx_ready=1 before it gives up on seeing busy
  localparam int unsigned BUSY_TIMEOUT  = 4;
  localparam int unsigned TMO_W         = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } drain_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: storage, pointers, occupancy, full/empty flags.
// Ports:
//   clk, resetn   - clock, async active-low reset
//   push, wdata   - enqueue request and data (ignored while full)
//   pop           - dequeue request (ignored while empty)
//   rdata_c       - head entry, combinational from the read pointer
//   level         - registered occupancy 0..DEPTH
//   full, empty   - registered occupancy flags
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DEPTH_BITS = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata_c,
  output logic [DEPTH_BITS:0]   level,
  output logic                  full,
  output logic                  empty
);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   level_q, level_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  push_ok;
  logic                  pop_ok;

  // Acceptance uses the pre-edge flags, so a same-cycle pop never frees room
  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & ~empty_q;

  // Next pointers, occupancy and flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + DEPTH_BITS'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + (DEPTH_BITS+1)'(1);
      2'b01:   level_d = level_q - (DEPTH_BITS+1)'(1);
      default: level_d = level_q;
    endcase
    full_d  = (level_d == (DEPTH_BITS+1)'(DEPTH));
    empty_d = (level_d == '0);
  end

  // Control state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array is not reset
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata_c = mem_q[rd_ptr_q];
  assign level   = level_q;
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/uart_tx_buffer.sv
// Transmit buffer between the UART-data MMIO write decode and the UART
// transmitter. Bytes are queued in a FIFO and drained one at a time by a
// send/handshake FSM.
// Ports:
//   clk, resetn        - clock, async active-low reset
//   wr_en, wr_data     - byte write strobe and data from MMIO decode
//   clr_ovf            - clears the sticky overflow flag
//   full, empty, level - FIFO status for the UART status word
//   overflow           - sticky: a write arrived while full and was dropped
//   tx_data, tx_send   - byte and one-cycle send request to the transmitter
//   tx_ready           - transmitter idle
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter int unsigned DEPTH_BITS = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                wr_en,
  input  logic [BYTE_W-1:0]   wr_data,
  input  logic                clr_ovf,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_BITS:0] level,
  output logic                overflow,
  output logic [BYTE_W-1:0]   tx_data,
  output logic                tx_send,
  input  logic                tx_ready
);

  drain_state_e      state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_send_q, tx_send_d;
  logic              overflow_q, overflow_d;
  logic              pop_c;
  logic [BYTE_W-1:0] head_c;

  sync_fifo #(
    .WIDTH      (BYTE_W),
    .DEPTH      (DEPTH),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (wr_en),
    .wdata   (wr_data),
    .pop     (pop_c),
    .rdata_c (head_c),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  // Drain FSM next state, pop request and registered outputs
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    tx_data_d = tx_data_q;
    pop_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty && tx_ready) begin
          pop_c     = 1'b1;
          tx_data_d = head_c;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        tmo_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // Never seeing busy means the request was missed or already finished
        if (!tx_ready) begin
          state_d = ST_WAIT_DONE;
        end else if (tmo_q == TMO_W'(BUSY_TIMEOUT - 1)) begin
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    tx_send_d  = (state_d == ST_SEND);
    // A drop in the same cycle as a clear keeps the flag set
    overflow_d = (overflow_q & ~clr_ovf) | (wr_en & full);
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      tmo_q      <= '0;
      tx_data_q  <= '0;
      tx_send_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      tx_data_q  <= tx_data_d;
      tx_send_q  <= tx_send_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_send  = tx_send_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Scoreboard bench for uart_tx_buffer: stimulus pushes expected bytes,
// a monitor pops and compares on every tx_send pulse.
module tb_uart_tx_buffer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned DB    = 4;

  logic          clk;
  logic          resetn;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          clr_ovf;
  logic          full;
  logic          empty;
  logic [DB:0]   level;
  logic          overflow;
  logic [7:0]    tx_data;
  logic          tx_send;
  logic          tx_ready;

  logic          model_mode;   // 1: busy-model transmitter drives tx_ready
  logic          model_ready;
  logic          man_ready;
  int            busy_cnt;

  logic [7:0]    exp_q [$];
  int            n_cmp;
  int            n_bad;
  int            send_cnt;
  logic          prev_send;

  assign tx_ready = model_mode ? model_ready : man_ready;

  uart_tx_buffer #(.DEPTH(DEPTH), .DEPTH_BITS(DB)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clr_ovf  (clr_ovf),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .tx_data  (tx_data),
    .tx_send  (tx_send),
    .tx_ready (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmitter model: 10 busy cycles after each send request
  initial begin
    model_ready = 1'b1;
    busy_cnt    = 0;
    forever begin
      @(negedge clk);
      if (model_mode) begin
        if (busy_cnt > 0) begin
          busy_cnt--;
          model_ready = (busy_cnt == 0);
        end else if (tx_send) begin
          busy_cnt    = 10;
          model_ready = 1'b0;
        end
      end
    end
  end

  // Monitor: every send pulse must match the next expected byte
  initial begin
    prev_send = 1'b0;
    send_cnt  = 0;
    forever begin
      @(negedge clk);
      if (resetn && tx_send) begin
        send_cnt++;
        check("send_pulse_width", int'(prev_send), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_send", int'(tx_data), -1);
        end else begin
          check("tx_data_order", int'(tx_data), int'(exp_q.pop_front()));
        end
      end
      prev_send = tx_send;
    end
  end

  // Drive one write over one clock edge; expected byte queued if it should go out
  task automatic write_byte(input logic [7:0] b, input bit expect_sent);
    wr_en   = 1'b1;
    wr_data = b;
    if (expect_sent) exp_q.push_back(b);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int max_cyc, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    n_cmp = 0; n_bad = 0;
    resetn = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0;
    model_mode = 1'b0; man_ready = 1'b1;

    // Reset values
    cycles(3);
    check("rst_level", int'(level), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_tx_send", int'(tx_send), 0);
    check("rst_tx_data", int'(tx_data), 0);
    resetn = 1'b1;
    cycles(2);

    // Single byte, latency and no duplicate with tx_ready held high
    base = send_cnt;
    write_byte(8'h41, 1'b1);
    @(negedge clk);
    check("single_send_e0", int'(tx_send), 0);
    check("single_level_e0", int'(level), 1);
    @(negedge clk);
    check("single_send_e1", int'(tx_send), 1);
    check("single_data_e1", int'(tx_data), 8'h41);
    check("single_level_e1", int'(level), 0);
    cycles(12);
    check("single_count", send_cnt - base, 1);
    check("single_hold_data", int'(tx_data), 8'h41);

    // Missed busy: every byte times out, one send each
    base = send_cnt;
    write_byte(8'h51, 1'b1);
    write_byte(8'h52, 1'b1);
    write_byte(8'h53, 1'b1);
    wait_drain(100, "missed_busy_drain");
    cycles(10);
    check("missed_busy_count", send_cnt - base, 3);

    // Burst against a busy transmitter
    model_mode = 1'b1;
    base = send_cnt;
    for (int i = 1; i <= 16; i++) write_byte(8'(i), 1'b1);
    wait_drain(600, "burst_drain");
    cycles(15);
    check("burst_count", send_cnt - base, 16);
    check("burst_overflow", int'(overflow), 0);
    check("burst_level", int'(level), 0);
    model_mode = 1'b0;

    // Overflow with transmitter not ready
    man_ready = 1'b0;
    for (int i = 0; i < 16; i++) write_byte(8'h20 + 8'(i), 1'b1);
    check("ovf_full_16", int'(full), 1);
    check("ovf_before_drop", int'(overflow), 0);
    write_byte(8'h30, 1'b0);
    check("ovf_set", int'(overflow), 1);
    check("ovf_level", int'(level), 16);
    clr_ovf = 1'b1; cycles(1); clr_ovf = 1'b0;
    check("ovf_cleared", int'(overflow), 0);
    clr_ovf = 1'b1;
    write_byte(8'h31, 1'b0);
    clr_ovf = 1'b0;
    check("ovf_set_wins", int'(overflow), 1);
    check("ovf_set_wins_level", int'(level), 16);
    clr_ovf = 1'b1; cycles(1); clr_ovf = 1'b0;
    check("ovf_cleared2", int'(overflow), 0);

    // Full with simultaneous pop: write still dropped
    man_ready = 1'b1;
    write_byte(8'hAA, 1'b0);
    check("fullpop_overflow", int'(overflow), 1);
    check("fullpop_level", int'(level), 15);
    check("fullpop_full", int'(full), 0);
    wait_drain(300, "fullpop_drain");
    cycles(10);
    clr_ovf = 1'b1; cycles(1); clr_ovf = 1'b0;

    // Reset during WAIT_DONE discards queued bytes
    man_ready = 1'b0;
    write_byte(8'h61, 1'b1);
    for (int i = 2; i <= 5; i++) write_byte(8'h60 + 8'(i), 1'b0);
    man_ready = 1'b1;
    @(posedge clk); #1;
    man_ready = 1'b0;
    cycles(2);
    check("midrst_level_pre", int'(level), 4);
    resetn = 1'b0;
    #1;
    check("midrst_level", int'(level), 0);
    check("midrst_empty", int'(empty), 1);
    check("midrst_tx_send", int'(tx_send), 0);
    check("midrst_tx_data", int'(tx_data), 0);
    cycles(2);
    base = send_cnt;
    resetn = 1'b1;
    man_ready = 1'b1;
    cycles(30);
    check("midrst_no_send", send_cnt - base, 0);
    check("midrst_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
